// File: rtl/arista_pkg_v.sv
// Shared constants for the AXI4-Lite to register-bus bridge: response codes,
// the timeout data pattern and the default timing parameters.
package arista_pkg_v;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam int unsigned RD_LAT_DEF  = 2;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Write wait cycles that follow the single register-bus write strobe.
    localparam int unsigned WR_WAIT_CYC = 2;

    // Which request type wins the next simultaneous read/write contest.
    typedef enum logic {
        PRI_RD = 1'b0,
        PRI_WR = 1'b1
    } rr_pri_t;

endpackage

// File: rtl/axil_reg_bridge_v.sv
// AXI4-Lite slave to single-strobe register bus. One transaction in flight,
// round-robin read/write arbitration, fixed read latency window followed by a
// bounded wait for reg_rvld that ends in a SLVERR/DEADBEEF response.
module axil_reg_bridge_v
    import arista_pkg_v::*;
#(
    parameter int unsigned RD_LAT_G  = RD_LAT_DEF,
    parameter int unsigned TIMEOUT_G = TIMEOUT_DEF
) (
    input  logic        reg_clk,
    input  logic        reg_rst_n,
    // write address / data / response
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    output logic [1:0]  s_axil_bresp,
    // read address / data
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    input  logic [31:0] s_axil_araddr,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    // register bus
    output logic        reg_avld,
    output logic [15:0] reg_addr,
    output logic        reg_wvld,
    output logic [31:0] reg_wdata,
    input  logic        reg_rvld,
    input  logic [31:0] reg_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    // Counter is cleared in the strobe cycle; wide enough for 15 + 255.
    localparam int unsigned        CNT_W   = 9;
    localparam logic [CNT_W-1:0]   LAT_END = CNT_W'(RD_LAT_G);
    localparam logic [CNT_W-1:0]   TMO_END = CNT_W'(RD_LAT_G + TIMEOUT_G - 1);
    localparam logic [CNT_W-1:0]   WR_END  = CNT_W'(WR_WAIT_CYC);

    state_t           state_q, state_d;
    rr_pri_t          rr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             reg_avld_q, reg_wvld_q;
    logic [15:0]      reg_addr_q;
    logic [31:0]      reg_wdata_q, rdata_q;
    logic [1:0]       rresp_q, bresp_q;

    logic idle, rd_elig, wr_elig, rd_grant, wr_grant, full_strb;
    logic in_window, rd_hit, rd_tmo;
    logic unused_addr_bits;

    // Ready outputs are combinational, so IDLE is additionally qualified by
    // reset to keep every ready at 0 while reg_rst_n is low.
    assign idle      = reg_rst_n && (state_q == ST_IDLE);
    assign rd_elig   = s_axil_arvalid;
    assign wr_elig   = s_axil_awvalid && s_axil_wvalid;
    assign rd_grant  = idle && rd_elig && (!wr_elig || (rr_q == PRI_RD));
    assign wr_grant  = idle && wr_elig && !rd_grant;
    assign full_strb = (s_axil_wstrb == 4'hF);

    // Sampling window opens RD_LAT_G cycles after the strobe cycle.
    assign in_window = (state_q == ST_RD_WAIT) && (cnt_q >= LAT_END);
    assign rd_hit    = in_window && reg_rvld;
    assign rd_tmo    = in_window && !reg_rvld && (cnt_q >= TMO_END);

    assign unused_addr_bits = ^{s_axil_awaddr[31:18], s_axil_awaddr[1:0],
                                s_axil_araddr[31:18], s_axil_araddr[1:0]};

    // State register.
    // NOTE: reset is sampled on the clock edge, and all state uses <= so every
    // flop sees pre-edge values regardless of block evaluation order.
    always_ff @(posedge reg_clk) begin
        if (!reg_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_grant)      state_d = ST_RD_WAIT;
                else if (wr_grant) state_d = full_strb ? ST_WR_WAIT : ST_WR_RESP;
            end
            ST_RD_WAIT: if (rd_hit || rd_tmo)  state_d = ST_RD_RESP;
            ST_WR_WAIT: if (cnt_q == WR_END)   state_d = ST_WR_RESP;
            ST_RD_RESP: if (s_axil_rready)     state_d = ST_IDLE;
            ST_WR_RESP: if (s_axil_bready)     state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // AXI handshake outputs decoded from the grant and the current state.
    always_comb begin
        s_axil_arready = rd_grant;
        s_axil_awready = wr_grant;
        s_axil_wready  = wr_grant;
        s_axil_rvalid  = (state_q == ST_RD_RESP);
        s_axil_bvalid  = (state_q == ST_WR_RESP);
    end

    // Datapath: register-bus strobes, captured responses, counter, arbiter.
    // NOTE: every datapath register is reset here because all of them are
    // visible on ports and must read 0 after reset.
    always_ff @(posedge reg_clk) begin
        if (!reg_rst_n) begin
            rr_q        <= PRI_RD;
            cnt_q       <= '0;
            reg_avld_q  <= 1'b0;
            reg_wvld_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            bresp_q     <= RESP_OKAY;
        end else begin
            reg_avld_q <= rd_grant || (wr_grant && full_strb);
            reg_wvld_q <= wr_grant && full_strb;

            if (rd_grant) begin
                reg_addr_q <= s_axil_araddr[17:2];
            end else if (wr_grant && full_strb) begin
                reg_addr_q  <= s_axil_awaddr[17:2];
                reg_wdata_q <= s_axil_wdata;
            end

            if (wr_grant) bresp_q <= full_strb ? RESP_OKAY : RESP_SLVERR;

            if (rd_grant || wr_grant) begin
                rr_q  <= rd_grant ? PRI_WR : PRI_RD;
                cnt_q <= '0;
            end else if ((state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) &&
                         (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (rd_hit) begin
                rdata_q <= reg_rdata;
                rresp_q <= RESP_OKAY;
            end else if (rd_tmo) begin
                rdata_q <= TIMEOUT_DATA;
                rresp_q <= RESP_SLVERR;
            end
        end
    end

    assign reg_avld     = reg_avld_q;
    assign reg_wvld     = reg_wvld_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = rresp_q;
    assign s_axil_bresp = bresp_q;

endmodule

// File: tb/tb_axil_reg_bridge_v.sv
// Self-checking bench for axil_reg_bridge_v: directed vector table, randomized
// transactions against a transaction-level model, plus arbitration and reset
// sequences. A behavioural register slave answers reads after rsp_dly cycles.
module tb_axil_reg_bridge_v;

    localparam int RD_LAT = 2;
    localparam int TMO    = 4;

    logic        reg_clk = 1'b0;
    logic        reg_rst_n;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_wvalid, s_axil_wready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_bvalid, s_axil_bready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_rvalid, s_axil_rready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        reg_avld, reg_wvld, reg_rvld;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata, reg_rdata;

    axil_reg_bridge_v #(.RD_LAT_G(RD_LAT), .TIMEOUT_G(TMO)) dut (
        .reg_clk(reg_clk), .reg_rst_n(reg_rst_n),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_araddr(s_axil_araddr),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .reg_avld(reg_avld), .reg_addr(reg_addr),
        .reg_wvld(reg_wvld), .reg_wdata(reg_wdata),
        .reg_rvld(reg_rvld), .reg_rdata(reg_rdata)
    );

    always #5 reg_clk = ~reg_clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;      // slave read delay after strobe, 0 = never answers
        int          hold;     // cycles rready/bready stay low after valid
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;  // cycles from ready handshake to valid
        int          exp_str;  // register-bus strobes expected
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] slave_mem [65536];
    logic [31:0] exp_mem   [65536];

    int          rsp_dly = 2;
    int          str_cnt = 0;
    logic [15:0] last_addr;
    logic        last_wvld;
    logic [31:0] last_wdata;
    int          wvld_alone = 0;
    int          avld_wide  = 0;
    logic        prev_avld  = 1'b0;
    int          cd         = 0;
    bit          rd_pend    = 0;
    logic [31:0] rd_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register slave and bus monitor, evaluated mid-cycle.
    always @(negedge reg_clk) begin
        reg_rvld  = 1'b0;
        reg_rdata = $urandom();
        if (reg_wvld && !reg_avld) wvld_alone++;
        if (reg_avld && prev_avld) avld_wide++;
        prev_avld = reg_avld;
        if (reg_avld) begin
            str_cnt++;
            last_addr  = reg_addr;
            last_wvld  = reg_wvld;
            last_wdata = reg_wdata;
            if (reg_wvld) begin
                slave_mem[reg_addr] = reg_wdata;
                rd_pend = 0;
            end else begin
                rd_pend = (rsp_dly > 0);
                cd      = rsp_dly;
                rd_val  = slave_mem[reg_addr];
            end
        end else if (rd_pend) begin
            if (cd == 1) begin
                reg_rvld  = 1'b1;
                reg_rdata = rd_val;
                rd_pend   = 0;
            end else begin
                cd--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                int dly, int hold, logic [31:0] ed, logic [1:0] er,
                                int el, int es);
        vec_t v;
        v.is_wr = w;  v.addr = a;  v.data = d;  v.strb = s;  v.dly = dly;  v.hold = hold;
        v.exp_data = ed;  v.exp_resp = er;  v.exp_lat = el;  v.exp_str = es;
        return v;
    endfunction

    // Transaction-level reference: outcome follows from strobe, delay and window.
    function automatic vec_t model(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                   int dly, int hold);
        vec_t v;
        v = mk(w, a, d, s, dly, hold, 32'h0, 2'b00, 0, 0);
        if (w) begin
            v.exp_resp = (s == 4'hF) ? 2'b00 : 2'b10;
            v.exp_lat  = (s == 4'hF) ? 2 + 2 : 1;
            v.exp_str  = (s == 4'hF) ? 1 : 0;
        end else begin
            v.exp_str = 1;
            if (dly >= RD_LAT && dly <= RD_LAT + TMO - 1) begin
                v.exp_data = exp_mem[a[17:2]];
                v.exp_resp = 2'b00;
                v.exp_lat  = dly + 2;
            end else begin
                v.exp_data = 32'hDEADBEEF;
                v.exp_resp = 2'b10;
                v.exp_lat  = 1 + RD_LAT + TMO;
            end
        end
        return v;
    endfunction

    task automatic rd_issue(input logic [31:0] addr);
        bit ok = 0;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge reg_clk);
            ok = s_axil_arready;
            @(posedge reg_clk); #1;
        end
        s_axil_arvalid = 1'b0;
        check("arready_seen", 32'(ok), 1);
    endtask

    task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok = 0;
        bit wr_ok = 0;
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge reg_clk);
            ok    = s_axil_awready;
            wr_ok = s_axil_wready;
            @(posedge reg_clk); #1;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("awready_seen", 32'(ok), 1);
        check("wready_with_awready", 32'(wr_ok), 32'(ok));
    endtask

    task automatic rd_finish(input int hold, input bit arm_ar,
                             output logic [31:0] d, output logic [1:0] r, output int lat);
        bit seen = 0;
        lat = 0;  d = '0;  r = '0;
        for (int i = 1; i <= 400 && !seen; i++) begin
            @(negedge reg_clk);
            if (s_axil_rvalid) begin
                seen = 1;
                lat  = i;
            end
        end
        check("rvalid_seen", 32'(seen), 1);
        if (seen) begin
            d = s_axil_rdata;
            r = s_axil_rresp;
            for (int h = 0; h < hold; h++) begin
                @(negedge reg_clk);
                check("rvalid_hold", 32'(s_axil_rvalid), 1);
                check("rdata_hold", s_axil_rdata, d);
                check("rresp_hold", 32'(s_axil_rresp), 32'(r));
            end
            s_axil_rready = 1'b1;
            if (arm_ar) s_axil_arvalid = 1'b1;
            @(posedge reg_clk); #1;
            s_axil_rready = 1'b0;
        end
    endtask

    task automatic wr_finish(input int hold, output logic [1:0] r, output int lat);
        bit seen = 0;
        lat = 0;  r = '0;
        for (int i = 1; i <= 400 && !seen; i++) begin
            @(negedge reg_clk);
            if (s_axil_bvalid) begin
                seen = 1;
                lat  = i;
            end
        end
        check("bvalid_seen", 32'(seen), 1);
        if (seen) begin
            r = s_axil_bresp;
            for (int h = 0; h < hold; h++) begin
                @(negedge reg_clk);
                check("bvalid_hold", 32'(s_axil_bvalid), 1);
                check("bresp_hold", 32'(s_axil_bresp), 32'(r));
            end
            s_axil_bready = 1'b1;
            @(posedge reg_clk); #1;
            s_axil_bready = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          s0;
        rsp_dly = v.dly;
        s0      = str_cnt;
        if (!v.is_wr) begin
            rd_issue(v.addr);
            rd_finish(v.hold, 1'b0, d, r, lat);
            check({tag, "_rdata"}, d, v.exp_data);
            check({tag, "_rresp"}, 32'(r), 32'(v.exp_resp));
            check({tag, "_rd_lat"}, lat, v.exp_lat);
            check({tag, "_rd_strobes"}, str_cnt - s0, v.exp_str);
            check({tag, "_rd_reg_addr"}, 32'(last_addr), 32'(v.addr[17:2]));
            check({tag, "_rd_reg_wvld"}, 32'(last_wvld), 0);
        end else begin
            wr_issue(v.addr, v.data, v.strb);
            wr_finish(v.hold, r, lat);
            check({tag, "_bresp"}, 32'(r), 32'(v.exp_resp));
            check({tag, "_wr_lat"}, lat, v.exp_lat);
            check({tag, "_wr_strobes"}, str_cnt - s0, v.exp_str);
            if (v.exp_str == 1) begin
                check({tag, "_wr_reg_addr"}, 32'(last_addr), 32'(v.addr[17:2]));
                check({tag, "_wr_reg_wvld"}, 32'(last_wvld), 1);
                check({tag, "_wr_reg_wdata"}, last_wdata, v.data);
            end
        end
        @(negedge reg_clk);
        check({tag, "_rvalid_idle"}, 32'(s_axil_rvalid), 0);
        check({tag, "_bvalid_idle"}, 32'(s_axil_bvalid), 0);
        @(posedge reg_clk); #1;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_arready"}, 32'(s_axil_arready), 0);
        check({tag, "_awready"}, 32'(s_axil_awready), 0);
        check({tag, "_wready"},  32'(s_axil_wready), 0);
        check({tag, "_rvalid"},  32'(s_axil_rvalid), 0);
        check({tag, "_bvalid"},  32'(s_axil_bvalid), 0);
        check({tag, "_reg_avld"}, 32'(reg_avld), 0);
        check({tag, "_reg_wvld"}, 32'(reg_wvld), 0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 0);
        check({tag, "_reg_wdata"}, reg_wdata, 0);
        check({tag, "_rdata"}, s_axil_rdata, 0);
        check({tag, "_rresp"}, 32'(s_axil_rresp), 0);
        check({tag, "_bresp"}, 32'(s_axil_bresp), 0);
    endtask

    // One cycle of grant observation with all requests raised.
    task automatic expect_grant(input string tag, input bit exp_rd);
        @(negedge reg_clk);
        check({tag, "_arready"}, 32'(s_axil_arready), 32'(exp_rd));
        check({tag, "_awready"}, 32'(s_axil_awready), 32'(!exp_rd));
        check({tag, "_wready"},  32'(s_axil_wready),  32'(!exp_rd));
        @(posedge reg_clk); #1;
    endtask

    initial begin
        vec_t        tbl [13];
        vec_t        v;
        logic [31:0] d, a;
        logic [1:0]  r;
        logic [3:0]  s;
        int          lat;
        int          rv;
        bit          w;

        for (int i = 0; i < 65536; i++) begin
            slave_mem[i] = 32'h1000_0000 | 32'(i);
            exp_mem[i]   = 32'h1000_0000 | 32'(i);
        end
        slave_mem[4] = 32'h1234_5678;
        exp_mem[4]   = 32'h1234_5678;

        //            wr  addr          data          strb  dly hold exp_data      resp  lat str
        tbl[0]  = mk(1, 32'h0000_0018, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0,        2'b00, 4, 1);
        tbl[1]  = mk(0, 32'h0000_0018, 32'h0,         4'h0, 2, 0, 32'hCAFE_F00D, 2'b00, 4, 1);
        tbl[2]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 2, 0, 32'h1234_5678, 2'b00, 4, 1);
        tbl[3]  = mk(1, 32'h0000_0020, 32'hFFFF_0000, 4'h3, 0, 0, 32'h0,        2'b10, 1, 0);
        tbl[4]  = mk(0, 32'h0000_0020, 32'h0,         4'h0, 2, 0, 32'h1000_0008, 2'b00, 4, 1);
        tbl[5]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, 2'b10, 7, 1);
        tbl[6]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 1, 0, 32'hDEAD_BEEF, 2'b10, 7, 1);
        tbl[7]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 5, 0, 32'h1234_5678, 2'b00, 7, 1);
        tbl[8]  = mk(0, 32'h0000_0010, 32'h0,         4'h0, 6, 0, 32'hDEAD_BEEF, 2'b10, 7, 1);
        tbl[9]  = mk(0, 32'hFFFC_0013, 32'h0,         4'h0, 2, 0, 32'h1234_5678, 2'b00, 4, 1);
        tbl[10] = mk(0, 32'h0000_0018, 32'h0,         4'h0, 3, 5, 32'hCAFE_F00D, 2'b00, 5, 1);
        tbl[11] = mk(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0, 5, 32'h0,        2'b00, 4, 1);
        tbl[12] = mk(0, 32'h0000_0040, 32'h0,         4'h0, 4, 2, 32'h0BAD_F00D, 2'b00, 6, 1);

        reg_rst_n      = 1'b0;
        s_axil_awvalid = 1'b0;  s_axil_awaddr = '0;
        s_axil_wvalid  = 1'b0;  s_axil_wdata  = '0;  s_axil_wstrb = '0;
        s_axil_bready  = 1'b0;
        s_axil_arvalid = 1'b0;  s_axil_araddr = '0;
        s_axil_rready  = 1'b0;

        repeat (3) @(posedge reg_clk);
        @(negedge reg_clk);
        chk_rst("por");
        @(posedge reg_clk); #1;
        reg_rst_n = 1'b1;
        @(posedge reg_clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].is_wr && tbl[i].strb == 4'hF) exp_mem[tbl[i].addr[17:2]] = tbl[i].data;
        end

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom();
            a[17:2] = 16'($urandom_range(0, 15));
            d = $urandom();
            s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
            v = model(w, a, d, s, $urandom_range(0, 7), $urandom_range(0, 3));
            run_txn(v, $sformatf("rnd%0d", i));
            if (w && s == 4'hF) exp_mem[a[17:2]] = d;
        end

        // Simultaneous requests twice: read wins, then write; slow rready/bready.
        rsp_dly        = 2;
        s_axil_araddr  = 32'h0000_0018;
        s_axil_awaddr  = 32'h0000_0044;
        s_axil_wdata   = 32'h5555_AAAA;
        s_axil_wstrb   = 4'hF;
        s_axil_arvalid = 1'b1;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        expect_grant("arb1", 1'b1);
        s_axil_arvalid = 1'b0;
        s_axil_araddr  = 32'h0000_0010;
        rd_finish(5, 1'b1, d, r, lat);
        check("arb1_rdata", d, exp_mem[6]);
        check("arb1_rresp", 32'(r), 0);
        check("arb1_rd_lat", lat, 4);
        expect_grant("arb2", 1'b0);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        exp_mem[16'h0011] = 32'h5555_AAAA;
        wr_finish(5, r, lat);
        check("arb2_bresp", 32'(r), 0);
        check("arb2_wr_lat", lat, 4);
        check("arb2_wdata", last_wdata, 32'h5555_AAAA);
        @(negedge reg_clk);
        check("arb3_arready", 32'(s_axil_arready), 1);
        @(posedge reg_clk); #1;
        s_axil_arvalid = 1'b0;
        rd_finish(0, 1'b0, d, r, lat);
        check("arb3_rdata", d, exp_mem[4]);
        check("arb3_rd_lat", lat, 4);
        run_txn(mk(0, 32'h0000_0044, 32'h0, 4'h0, 2, 0, 32'h5555_AAAA, 2'b00, 4, 1), "arb_rb");

        // Reset while waiting for read data: transaction dropped, no response.
        rsp_dly = 3;
        rd_issue(32'h0000_0010);
        @(posedge reg_clk); #1;
        reg_rst_n = 1'b0;
        @(posedge reg_clk);
        @(negedge reg_clk);
        chk_rst("midrst");
        @(posedge reg_clk); #1;
        reg_rst_n = 1'b1;
        rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge reg_clk);
            rv += int'(s_axil_rvalid) + int'(s_axil_bvalid);
        end
        check("midrst_no_response", rv, 0);
        @(posedge reg_clk); #1;

        // Arbiter pointer is back on read after reset; read and write both complete.
        rsp_dly        = 2;
        s_axil_araddr  = 32'h0000_0018;
        s_axil_awaddr  = 32'h0000_0048;
        s_axil_wdata   = 32'h600D_CAFE;
        s_axil_wstrb   = 4'hF;
        s_axil_arvalid = 1'b1;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        expect_grant("post_rst", 1'b1);
        s_axil_arvalid = 1'b0;
        rd_finish(0, 1'b0, d, r, lat);
        check("post_rst_rdata", d, exp_mem[6]);
        check("post_rst_rresp", 32'(r), 0);
        check("post_rst_rd_lat", lat, 4);
        expect_grant("post_rst_wr", 1'b0);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        exp_mem[16'h0012] = 32'h600D_CAFE;
        wr_finish(0, r, lat);
        check("post_rst_bresp", 32'(r), 0);
        run_txn(mk(0, 32'h0000_0048, 32'h0, 4'h0, 2, 0, 32'h600D_CAFE, 2'b00, 4, 1), "post_rst_rb");

        check("wvld_without_avld", wvld_alone, 0);
        check("avld_longer_than_1", avld_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
